// File: rtl/frame_windower.sv
// Purpose: buffers samples into overlapping FRAME_LEN frames (HOP advance) and emits each windowed frame oldest-first.
// Latency: 2 cycles from buffer read / coef_addr issue to out_data/out_valid; bursts are FRAME_LEN contiguous cycles.
// Backpressure: in_ready is low while a frame is being read out; the output side has no backpressure.
module frame_windower #(
    parameter int WIDTH      = 8,
    parameter int COEF_WIDTH = 8,
    parameter int FRAME_LEN  = 128,
    parameter int HOP        = 64,
    parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last
);
    localparam int PW = WIDTH + COEF_WIDTH + 1;

    typedef enum logic [1:0] {FILL, EMIT, HOP_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   k_q, k_d;
    logic                    in_ready_q, in_ready_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    rd_last_q, rd_last_d;
    logic signed [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic signed [WIDTH-1:0] mem [FRAME_LEN];
    logic                    accept;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    rnd;
    logic                    unused_rnd;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == ADDR_WIDTH'(FRAME_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOP_WAIT: begin
                if (accept) begin
                    if (cnt_q == ADDR_WIDTH'(HOP - 1)) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // k wraps back to 0 on the last issue, leaving coef_addr at 0 while idle
                k_d = k_q + 1'b1;
                if (k_q == ADDR_WIDTH'(FRAME_LEN - 1)) begin
                    state_d = HOP_WAIT;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d = (state_d != EMIT);

        rd_vld_d  = (state_q == EMIT);
        rd_last_d = (state_q == EMIT) && (k_q == ADDR_WIDTH'(FRAME_LEN - 1));
        samp_d    = mem[wr_ptr_q + k_q];

        // coef_data belongs to the sample read last cycle; round half up then drop the fraction
        prod = PW'(samp_q) * PW'($signed({1'b0, coef_data}));
        rnd  = prod + PW'(2 ** (COEF_WIDTH - 1));

        out_data_d  = rnd[COEF_WIDTH +: WIDTH];
        out_valid_d = rd_vld_q;
        out_last_d  = rd_last_q;
    end

    assign unused_rnd = ^{rnd[PW-1], rnd[COEF_WIDTH-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            samp_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            samp_q      <= samp_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign coef_addr = k_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_frame_windower.sv
// Bench for frame_windower with FRAME_LEN=8, HOP=4: table of frames with hand-computed bursts,
// plus hand sequences for coef_addr stepping, input backpressure and reset in the middle of a burst.
module tb_frame_windower;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] coef_addr;
    logic [7:0] coef_data = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;

    frame_windower #(
        .WIDTH(8), .COEF_WIDTH(8), .FRAME_LEN(8), .HOP(4), .ADDR_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [8];
    always @(posedge clk) coef_data <= rom[coef_addr];

    typedef struct packed {
        logic signed [7:0] d;
        logic              last;
    } exp_t;

    typedef struct packed {
        int              nsamp;
        logic [7:0][7:0] s;
        logic [7:0]      coef;
        logic [7:0][7:0] e;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vld_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0][7:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][7:0] r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0]; r[3] = a3[7:0];
        r[4] = a4[7:0]; r[5] = a5[7:0]; r[6] = a6[7:0]; r[7] = a7[7:0];
        return r;
    endfunction

    task automatic set_rom(input logic [7:0] c);
        for (int i = 0; i < 8; i++) rom[i] = c;
    endtask

    task automatic push_frame(input logic [7:0][7:0] e);
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            x.d    = $signed(e[i]);
            x.last = (i == 7);
            exp_q.push_back(x);
        end
    endtask

    task automatic send(input int x);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x[7:0];
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    // Output monitor: every valid output must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            exp_t e;
            vld_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", int'($signed(out_data)), int'(e.d));
                chk("out_last", int'(out_last), int'(e.last));
            end
        end
    end

    vec_t tbl [4];

    initial begin
        tbl[0] = '{nsamp: 8, s: p8(1, 2, 3, 4, 5, 6, 7, 8), coef: 8'd128,
                   e: p8(1, 1, 2, 2, 3, 3, 4, 4)};
        tbl[1] = '{nsamp: 4, s: p8(9, 10, 11, 12, 0, 0, 0, 0), coef: 8'd255,
                   e: p8(5, 6, 7, 8, 9, 10, 11, 12)};
        tbl[2] = '{nsamp: 4, s: p8(-128, 127, 0, -1, 0, 0, 0, 0), coef: 8'd255,
                   e: p8(9, 10, 11, 12, -127, 127, 0, -1)};
        tbl[3] = '{nsamp: 4, s: p8(20, 21, 22, 23, 0, 0, 0, 0), coef: 8'd0,
                   e: p8(0, 0, 0, 0, 0, 0, 0, 0)};
        set_rom(8'd0);

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_coef_addr", int'(coef_addr), 0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("in_ready_after_release", int'(in_ready), 1);

        for (int t = 0; t < 4; t++) begin
            set_rom(tbl[t].coef);
            for (int i = 0; i < tbl[t].nsamp; i++) send(int'($signed(tbl[t].s[i])));
            push_frame(tbl[t].e);
            chk("in_ready_in_emit", int'(in_ready), 0);
            if (t == 0) begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("coef_addr_step", int'(coef_addr), k);
                end
                @(negedge clk);
                chk("in_ready_after_emit", int'(in_ready), 1);
                chk("coef_addr_idle", int'(coef_addr), 0);
            end
            wait_empty("burst_complete");
        end

        // Backpressure: 13 is held through the burst and must land at k=4 of the next frame
        set_rom(8'd255);
        for (int i = 30; i < 34; i++) send(i);
        push_frame(p8(20, 21, 22, 23, 30, 31, 32, 33));
        chk("bp_in_ready_low", int'(in_ready), 0);
        for (int i = 13; i < 17; i++) send(i);
        push_frame(p8(30, 31, 32, 33, 13, 14, 15, 16));
        wait_empty("bp_bursts_complete");

        // Reset after 3 outputs of a burst
        for (int i = 40; i < 44; i++) send(i);
        push_frame(p8(13, 14, 15, 16, 40, 41, 42, 43));
        for (int n = 0; n < 100 && exp_q.size() > 5; n++) begin
            @(negedge clk);
            #1;
        end
        chk("three_outputs_before_rst", exp_q.size(), 5);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_coef_addr", int'(coef_addr), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("in_ready_after_midrst", int'(in_ready), 1);

        vld_seen = 0;
        for (int i = 50; i < 57; i++) send(i);
        repeat (20) @(negedge clk);
        chk("no_burst_after_7", vld_seen, 0);
        send(57);
        push_frame(p8(50, 51, 52, 53, 54, 55, 56, 57));
        wait_empty("refill_burst_complete");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
